// File: rtl/ads42_spi_slave.sv
// ads42_spi_slave: SPI responder for the ADS42 configuration interface.
// Oversamples cs_n / spi_clk / mosi in sys_clk, decodes 16-bit frames
// (R/W, 7-bit address, 8-bit data, MSB first) against a local register map
// and drives read data on MISO.
// Optional: define ADS42_SPI_SLV_ERR_CNT_EN to build the saturating frame
// error counter on o_err_cnt; otherwise o_err_cnt is tied to zero.
module ads42_spi_slave #(
  parameter int REG_NUM     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       i_cs_n,
  input  logic       i_spi_clk,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  input  logic [6:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic       o_wr_en,
  output logic [6:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_rd_done,
  output logic       o_frame_err,
  output logic [7:0] o_err_cnt
);

  localparam int         AW        = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [7:0] REG_NUM_W = 8'(REG_NUM);
  // Synchronizer bit order is {cs_n, spi_clk, mosi}; cs_n idles high.
  localparam logic [2:0] SYNC_RST  = 3'b100;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  logic [2:0]           sync_reg [SYNC_STAGES];
  logic [2:0]           sync_out;
  logic [1:0]           edge_reg;
  logic [SYNC_STAGES:0] prime_reg;
  logic                 primed;
  logic                 cs_fall, cs_rise, spi_rise, spi_fall, mosi_s;

  state_t               state;
  logic [7:0]           shift_reg;
  logic [7:0]           sr_shift;
  logic [4:0]           bit_cnt;
  logic [4:0]           cnt_inc;
  logic                 rw_reg;
  logic [6:0]           addr_reg;
  logic [7:0]           tx_sr;
  logic [7:0]           cmd_rd_data;
  logic                 addr_ok;
  logic [7:0]           regfile [REG_NUM];

  // Synchronizer chains, one stage per generate iteration
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First stage samples the raw pins
        always_ff @(posedge sys_clk or posedge rst) begin
          if (rst) sync_reg[gi] <= SYNC_RST;
          else     sync_reg[gi] <= {i_cs_n, i_spi_clk, i_mosi};
        end
      end else begin : g_next
        // Later stages follow the previous one
        always_ff @(posedge sys_clk or posedge rst) begin
          if (rst) sync_reg[gi] <= SYNC_RST;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // Edge-detect flops, plus a priming chain so that no edge is reported
  // until the synchronizers hold post-reset samples (a cs_n still low at
  // reset release must not look like a new frame start)
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      edge_reg  <= SYNC_RST[2:1];
      prime_reg <= '0;
    end else begin
      edge_reg  <= sync_out[2:1];
      prime_reg <= {prime_reg[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign primed   = prime_reg[SYNC_STAGES];
  assign cs_fall  = primed &  edge_reg[1] & ~sync_out[2];
  assign cs_rise  = primed & ~edge_reg[1] &  sync_out[2];
  assign spi_rise = primed & ~edge_reg[0] &  sync_out[1];
  assign spi_fall = primed &  edge_reg[0] & ~sync_out[1];
  assign mosi_s   = sync_out[0];

  // Next shift/count values and the register lookup for a read command
  always_comb begin
    sr_shift    = {shift_reg[6:0], mosi_s};
    cnt_inc     = (bit_cnt == 5'd17) ? 5'd17 : bit_cnt + 5'd1;
    cmd_rd_data = 8'h00;
    if ({1'b0, sr_shift[6:0]} < REG_NUM_W)
      cmd_rd_data = regfile[sr_shift[AW-1:0]];
    addr_ok     = ({1'b0, addr_reg} < REG_NUM_W);
  end

  // Frame decoder, MISO driver and register map
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      rw_reg      <= 1'b0;
      addr_reg    <= '0;
      tx_sr       <= '0;
      o_miso      <= 1'b0;
      o_miso_oe   <= 1'b0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_rd_done   <= 1'b0;
      o_frame_err <= 1'b0;
      for (int i = 0; i < REG_NUM; i++) regfile[i] <= 8'h00;
    end else begin
      o_wr_en     <= 1'b0;
      o_rd_done   <= 1'b0;
      o_frame_err <= 1'b0;
      if (cs_rise) begin
        // A rise coinciding with cs_rise still counts before the close
        if (spi_rise && (state == CMD || state == DATA)) begin
          shift_reg <= sr_shift;
          bit_cnt   <= cnt_inc;
        end
        o_miso    <= 1'b0;
        o_miso_oe <= 1'b0;
        state     <= DONE;
      end else if (cs_fall && state != IDLE) begin
        // Restart without committing anything
        shift_reg <= '0;
        bit_cnt   <= '0;
        tx_sr     <= '0;
        o_miso    <= 1'b0;
        o_miso_oe <= 1'b0;
        state     <= CMD;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              shift_reg <= '0;
              bit_cnt   <= '0;
              state     <= CMD;
            end
          end
          CMD: begin
            if (spi_rise) begin
              shift_reg <= sr_shift;
              bit_cnt   <= cnt_inc;
              if (bit_cnt == 5'd7) begin
                rw_reg    <= sr_shift[7];
                addr_reg  <= sr_shift[6:0];
                tx_sr     <= cmd_rd_data;
                o_miso_oe <= sr_shift[7];
                state     <= DATA;
              end
            end
          end
          DATA: begin
            if (spi_rise) begin
              shift_reg <= sr_shift;
              bit_cnt   <= cnt_inc;
            end
            if (spi_fall && rw_reg) begin
              o_miso <= tx_sr[7];
              tx_sr  <= {tx_sr[6:0], 1'b0};
            end
          end
          DONE: begin
            if (bit_cnt == 5'd16) begin
              if (!rw_reg) begin
                if (addr_ok) begin
                  o_wr_en   <= 1'b1;
                  o_wr_addr <= addr_reg;
                  o_wr_data <= shift_reg;
                  // Bit0 of register 0 is a soft reset and is never stored
                  if (addr_reg == 7'd0 && shift_reg[0])
                    for (int i = 0; i < REG_NUM; i++) regfile[i] <= 8'h00;
                  else
                    regfile[addr_reg[AW-1:0]] <= shift_reg;
                end
              end else begin
                o_rd_done <= 1'b1;
              end
            end else begin
              o_frame_err <= 1'b1;
            end
            // Cleared so a stray cs_rise in IDLE can never re-commit
            bit_cnt <= '0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Fabric-side observe port, one cycle of latency
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)
      o_rd_data <= 8'h00;
    else if ({1'b0, i_rd_addr} < REG_NUM_W)
      o_rd_data <= regfile[i_rd_addr[AW-1:0]];
    else
      o_rd_data <= 8'h00;
  end

`ifdef ADS42_SPI_SLV_ERR_CNT_EN
  // Saturating count of bad frames, cleared only by rst
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)
      o_err_cnt <= 8'h00;
    else if (o_frame_err && o_err_cnt != 8'hFF)
      o_err_cnt <= o_err_cnt + 8'h01;
  end
`else
  assign o_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ads42_spi_slave.sv
// tb_ads42_spi_slave: randomized frames against a register-map reference
// model; the master runs spi_clk at sys_clk/20.
module tb_ads42_spi_slave;

  localparam int REG_NUM = 16;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       cs_n    = 1'b1;
  logic       spi_clk = 1'b0;
  logic       mosi    = 1'b0;
  logic [6:0] rd_addr = 7'd0;
  logic       miso, miso_oe, wr_en, rd_done, frame_err;
  logic [7:0] rd_data, wr_data, err_cnt;
  logic [6:0] wr_addr;

  ads42_spi_slave #(.REG_NUM(REG_NUM), .SYNC_STAGES(2)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .i_cs_n     (cs_n),
    .i_spi_clk  (spi_clk),
    .i_mosi     (mosi),
    .o_miso     (miso),
    .o_miso_oe  (miso_oe),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_rd_done  (rd_done),
    .o_frame_err(frame_err),
    .o_err_cnt  (err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference register map and expected error count
  logic [7:0] model [128];
  int         exp_err_cnt = 0;

  // Pulse monitor
  int         wr_pulses  = 0;
  int         rd_pulses  = 0;
  int         err_pulses = 0;
  logic [6:0] last_wa    = 7'd0;
  logic [7:0] last_wd    = 8'd0;

  always @(negedge sys_clk) begin
    if (!rst) begin
      if (wr_en) begin
        wr_pulses++;
        last_wa = wr_addr;
        last_wd = wr_data;
      end
      if (rd_done)   rd_pulses++;
      if (frame_err) err_pulses++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
  endtask

  // Master side: drive on fall, slave samples on rise; MISO/OE captured
  // just before each rise
  task automatic do_frame(input logic [15:0] word, input int nbits,
                          output logic [15:0] rx, output logic [15:0] oe_mask);
    rx      = '0;
    oe_mask = '0;
    cs_n    = 1'b0;
    wait_cyc(10);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? word[15-i] : 1'b0;
      wait_cyc(10);
      rx      = {rx[14:0], miso};
      oe_mask = {oe_mask[14:0], miso_oe};
      spi_clk = 1'b1;
      wait_cyc(10);
      spi_clk = 1'b0;
    end
    wait_cyc(10);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_cyc(20);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] word, input int nbits);
    int         w0, r0, e0;
    logic [15:0] rx, oe_mask;
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  data, exp_rd;
    w0   = wr_pulses;
    r0   = rd_pulses;
    e0   = err_pulses;
    rw   = word[15];
    addr = word[14:8];
    data = word[7:0];
    exp_rd = (int'(addr) < REG_NUM) ? model[addr] : 8'h00;
    do_frame(word, nbits, rx, oe_mask);
    $display("frame %s word=%04h bits=%0d miso=%02h oe=%04h", tag, word, nbits, rx[7:0], oe_mask);
    if (nbits == 16) begin
      check({tag, "_err"}, 32'(err_pulses - e0), 32'd0);
      if (!rw) begin
        check({tag, "_rdn"}, 32'(rd_pulses - r0), 32'd0);
        check({tag, "_oe"}, 32'(oe_mask), 32'h0);
        if (int'(addr) < REG_NUM) begin
          check({tag, "_wrn"}, 32'(wr_pulses - w0), 32'd1);
          check({tag, "_wa"}, 32'(last_wa), 32'(addr));
          check({tag, "_wd"}, 32'(last_wd), 32'(data));
          if (addr == 7'd0 && data[0]) model_clear();
          else model[addr] = data;
        end else begin
          check({tag, "_wrn"}, 32'(wr_pulses - w0), 32'd0);
        end
      end else begin
        check({tag, "_wrn"}, 32'(wr_pulses - w0), 32'd0);
        check({tag, "_rdn"}, 32'(rd_pulses - r0), 32'd1);
        check({tag, "_miso"}, 32'(rx[7:0]), 32'(exp_rd));
        check({tag, "_oe"}, 32'(oe_mask), 32'h00FF);
      end
    end else begin
      check({tag, "_err"}, 32'(err_pulses - e0), 32'd1);
      check({tag, "_wrn"}, 32'(wr_pulses - w0), 32'd0);
      check({tag, "_rdn"}, 32'(rd_pulses - r0), 32'd0);
      if (exp_err_cnt < 255) exp_err_cnt++;
    end
    check({tag, "_oe_end"}, 32'(miso_oe), 32'd0);
`ifdef ADS42_SPI_SLV_ERR_CNT_EN
    check({tag, "_ecnt"}, 32'(err_cnt), 32'(exp_err_cnt));
`else
    check({tag, "_ecnt"}, 32'(err_cnt), 32'd0);
`endif
  endtask

  // Observe port sweep including out-of-range addresses
  task automatic check_regs(input string tag);
    logic [7:0] exp;
    for (int a = 0; a < REG_NUM + 2; a++) begin
      rd_addr = (a == REG_NUM + 1) ? 7'h7F : 7'(a);
      wait_cyc(1);
      exp = (a < REG_NUM) ? model[a] : 8'h00;
      check($sformatf("%s_reg%0h", tag, rd_addr), 32'(rd_data), 32'(exp));
    end
  endtask

  initial begin
    int w0;
    int nb;
    logic [15:0] word;
    model_clear();

    // Reset state
    wait_cyc(5);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_oe", 32'(miso_oe), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    rst = 1'b0;
    wait_cyc(5);

    // Write then observe, read back over SPI
    run_frame("wr0A", 16'h0A5C, 16);
    rd_addr = 7'h0A;
    wait_cyc(1);
    check("obs0A", 32'(rd_data), 32'h5C);
    run_frame("rd0A", 16'h8A00, 16);

    // Out-of-range read and write
    run_frame("rd7F", 16'hFF00, 16);
    run_frame("wr7F", 16'h7F33, 16);
    check_regs("oor");

    // Truncated and over-long frames leave reg 3 alone
    run_frame("wr03", 16'h03AA, 16);
    run_frame("trunc", 16'h03FF, 12);
    run_frame("long", 16'h03FF, 17);
    check_regs("err");

    // Soft reset through register 0 bit0
    for (int a = 1; a <= 5; a++)
      run_frame($sformatf("ld%0d", a), {1'b0, 7'(a), 8'($urandom_range(1, 255))}, 16);
    run_frame("srst", 16'h0001, 16);
    check_regs("srst");

    // Randomized frames
    for (int k = 0; k < 30; k++) begin
      word = 16'($urandom);
      word[14:8] = 7'($urandom_range(0, 19));
      if ($urandom_range(0, 5) == 0) word[14:8] = 7'h7F;
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 17)) : 16;
      run_frame($sformatf("rnd%0d", k), word, nb);
    end
    check_regs("rnd");

    // Reset in the middle of a write frame
    run_frame("pre_rst", 16'h0477, 16);
    w0 = wr_pulses;
    cs_n = 1'b0;
    wait_cyc(10);
    for (int i = 0; i < 10; i++) begin
      mosi = 1'b1;
      wait_cyc(10);
      spi_clk = 1'b1;
      wait_cyc(10);
      spi_clk = 1'b0;
    end
    rst = 1'b1;
    wait_cyc(2);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_oe", 32'(miso_oe), 32'd0);
    check("mid_rst_rd_data", 32'(rd_data), 32'd0);
    check("mid_rst_ecnt", 32'(err_cnt), 32'd0);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    model_clear();
    exp_err_cnt = 0;
    wait_cyc(10);
    check("mid_rst_no_wr", 32'(wr_pulses - w0), 32'd0);
    check_regs("post_rst");
    run_frame("post_rst_wr", 16'h0966, 16);
    run_frame("post_rst_rd", 16'h8900, 16);

`ifdef ADS42_SPI_SLV_ERR_CNT_EN
    // Drive the error counter into saturation with empty frames
    w0 = err_pulses;
    for (int k = 0; k < 300; k++) begin
      cs_n = 1'b0;
      wait_cyc(6);
      cs_n = 1'b1;
      wait_cyc(6);
      if (exp_err_cnt < 255) exp_err_cnt++;
    end
    wait_cyc(5);
    $display("burst of 300 empty frames err_cnt=%02h", err_cnt);
    check("burst_pulses", 32'(err_pulses - w0), 32'd300);
    check("burst_ecnt", 32'(err_cnt), 32'(exp_err_cnt));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
